// File: rtl/key_seq_ctrl.sv
// Debounced pushbutton sequencer: short press increments a 4-bit working
// register, long press inverts it, load_en overrides both.
module key_seq_ctrl #(
    parameter int unsigned DEB_CYC  = 'd1_000_000,
    parameter int unsigned LONG_CYC = 'h8F0D180
) (
    input  logic       FPGA_CLK,
    input  logic       FPGA_RST_N,
    input  logic       key_raw,
    input  logic       load_en,
    input  logic [3:0] load_data,
    output logic [3:0] data_out,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic [2:0] key_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HELD      = 3'd2,
        LONG      = 3'd3,
        DEB_REL   = 3'd4
    } state_e;

    localparam logic [27:0] DEB_LAST  = 28'(DEB_CYC - 1);
    localparam logic [27:0] LONG_LAST = 28'(LONG_CYC - 1);
    localparam logic [27:0] CNT_MAX   = '1;

    state_e      state_q;
    logic        sync1_q, key_s_q;
    logic [27:0] cnt_q, rel_q;
    logic        pend_q;
    logic        short_q, long_q;
    logic [3:0]  data_q, dout_q;

    logic        short_d, long_d;
    logic [27:0] cnt_sat;

    // Pulse decisions feed both the pulse registers and the data register,
    // so the data operation lands on the same edge the strobe rises.
    always_comb begin
        long_d  = (state_q == HELD) && key_s_q && (cnt_q >= LONG_LAST);
        short_d = (state_q == DEB_REL) && !key_s_q && (rel_q == DEB_LAST) && pend_q;
        cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 28'd1;
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            key_s_q <= 1'b0;
            cnt_q   <= '0;
            rel_q   <= '0;
            pend_q  <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            data_q  <= 4'h0;
            dout_q  <= 4'h0;
        end else begin
            sync1_q <= key_raw;
            key_s_q <= sync1_q;
            short_q <= short_d;
            long_q  <= long_d;
            dout_q  <= data_q;

            if (load_en)      data_q <= load_data;
            else if (long_d)  data_q <= ~data_q;
            else if (short_d) data_q <= data_q + 4'd1;

            case (state_q)
                IDLE: begin
                    if (key_s_q) begin
                        state_q <= DEB_PRESS;
                        cnt_q   <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!key_s_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 28'd1;
                        if (cnt_q == DEB_LAST) state_q <= HELD;
                    end
                end
                HELD: begin
                    if (!key_s_q) begin
                        state_q <= DEB_REL;
                        rel_q   <= '0;
                        pend_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_sat;
                        if (long_d) state_q <= LONG;
                    end
                end
                LONG: begin
                    if (!key_s_q) begin
                        state_q <= DEB_REL;
                        rel_q   <= '0;
                        pend_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                DEB_REL: begin
                    // A bounce back to pressed resumes the press with its count intact.
                    if (key_s_q) begin
                        state_q <= pend_q ? HELD : LONG;
                    end else if (rel_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        rel_q   <= '0;
                        pend_q  <= 1'b0;
                    end else begin
                        rel_q <= rel_q + 28'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out    = dout_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign key_state   = state_q;

endmodule

// File: tb/tb_key_seq_ctrl.sv
// Bench for key_seq_ctrl: directed press scenarios plus random key/load
// traffic, compared each clock against a press-level behavioural model.
module tb_key_seq_ctrl;
    localparam int DEB = 4;
    localparam int LNG = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_raw = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_data = 4'h0;
    logic [3:0] data_out;
    logic       short_pulse, long_pulse;
    logic [2:0] key_state;

    always #5 clk = ~clk;

    key_seq_ctrl #(.DEB_CYC(DEB), .LONG_CYC(LNG)) dut (
        .FPGA_CLK   (clk),
        .FPGA_RST_N (rst_n),
        .key_raw    (key_raw),
        .load_en    (load_en),
        .load_data  (load_data),
        .data_out   (data_out),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse),
        .key_state  (key_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_sh  = 0;
    int n_lg  = 0;

    // Reference: a press is active, debounced or not, releasing or not,
    // and has counted pressed clocks / released clocks.
    bit       m_s1, m_ks;
    bit       m_act, m_deb, m_rel, m_longed;
    int       m_pn, m_rn;
    logic [3:0] m_data, m_dout;
    bit       m_sh, m_lg;

    function automatic int m_state();
        if (!m_act)   return 0;
        if (!m_deb)   return 1;
        if (m_rel)    return 4;
        if (m_longed) return 3;
        return 2;
    endfunction

    function automatic void model_reset();
        m_s1 = 0; m_ks = 0; m_act = 0; m_deb = 0; m_rel = 0; m_longed = 0;
        m_pn = 0; m_rn = 0; m_data = 4'h0; m_dout = 4'h0; m_sh = 0; m_lg = 0;
    endfunction

    function automatic void model_step(input bit kr, input bit le, input logic [3:0] ld);
        bit ks;
        ks = m_ks;
        m_sh = 0;
        m_lg = 0;
        if (!m_act) begin
            if (ks) begin
                m_act = 1; m_deb = 0; m_rel = 0; m_longed = 0; m_pn = 0;
            end
        end else if (!m_deb) begin
            if (ks) begin
                if (m_pn == DEB - 1) m_deb = 1;
                m_pn++;
            end else begin
                m_act = 0;
            end
        end else if (m_rel) begin
            if (ks) m_rel = 0;
            else if (m_rn == DEB - 1) begin
                m_act = 0;
                m_sh = !m_longed;
            end else m_rn++;
        end else begin
            if (ks) begin
                if (!m_longed && m_pn == LNG - 1) begin
                    m_lg = 1;
                    m_longed = 1;
                end
                if (m_pn < (1 << 28) - 1) m_pn++;
            end else begin
                m_rel = 1;
                m_rn = 0;
            end
        end
        m_dout = m_data;
        if (le)        m_data = ld;
        else if (m_lg) m_data = ~m_data;
        else if (m_sh) m_data = m_data + 4'd1;
        m_ks = m_s1;
        m_s1 = kr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked on the next one.
    task automatic cyc(input bit kr, input bit le, input logic [3:0] ld);
        key_raw = kr;
        load_en = le;
        load_data = ld;
        @(posedge clk);
        model_step(kr, le, ld);
        @(negedge clk);
        chk("state", 32'(key_state), 32'(m_state()));
        chk("short", 32'(short_pulse), 32'(m_sh));
        chk("long", 32'(long_pulse), 32'(m_lg));
        chk("dout", 32'(data_out), 32'(m_dout));
        chk("excl", 32'(short_pulse & long_pulse), 32'd0);
        n_sh += int'(short_pulse);
        n_lg += int'(long_pulse);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_state", 32'(key_state), 32'd0);
        chk("rst_short", 32'(short_pulse), 32'd0);
        chk("rst_long", 32'(long_pulse), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 4'h0);
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // load 5, short press -> 6
        cyc(0, 1, 4'h5); idle(3);
        n_sh = 0; n_lg = 0;
        repeat (8) cyc(1, 0, 4'h0); idle(12);
        chk("s1_short_n", n_sh, 1); chk("s1_long_n", n_lg, 0);
        chk("s1_dout", 32'(data_out), 32'h6);

        // load A, long press -> 5, no short on release
        cyc(0, 1, 4'hA); idle(3);
        n_sh = 0; n_lg = 0;
        repeat (40) cyc(1, 0, 4'h0); idle(12);
        chk("s2_long_n", n_lg, 1); chk("s2_short_n", n_sh, 0);
        chk("s2_dout", 32'(data_out), 32'h5);

        // 2-clock glitch rejected
        n_sh = 0; n_lg = 0;
        repeat (2) cyc(1, 0, 4'h0); idle(8);
        chk("s3_pulses", n_sh + n_lg, 0);
        chk("s3_state", 32'(key_state), 32'd0);
        chk("s3_dout", 32'(data_out), 32'h5);

        // F + 1 wraps to 0
        cyc(0, 1, 4'hF); idle(3);
        n_sh = 0;
        repeat (8) cyc(1, 0, 4'h0); idle(12);
        chk("s4_short_n", n_sh, 1);
        chk("s4_dout", 32'(data_out), 32'h0);

        // release bounce inside HELD keeps the press count
        n_sh = 0; n_lg = 0;
        repeat (10) cyc(1, 0, 4'h0); repeat (2) cyc(0, 0, 4'h0);
        repeat (12) cyc(1, 0, 4'h0); idle(12);
        chk("s5_long_n", n_lg, 1); chk("s5_short_n", n_sh, 0);
        chk("s5_dout", 32'(data_out), 32'hF);

        // reset mid-press, key held: full requalification, load wins on long clock
        n_sh = 0; n_lg = 0;
        repeat (15) cyc(1, 0, 4'h0);
        chk("s6_pre_long", n_lg, 0);
        do_reset();
        n_sh = 0; n_lg = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc(1, i == 23, 4'h3);
            if (i == 22) chk("s6_no_early", n_lg, 0);
            if (i == 23) chk("s6_long_edge", 32'(long_pulse), 32'd1);
        end
        idle(12);
        chk("s6_long_n", n_lg, 1); chk("s6_short_n", n_sh, 0);
        chk("s6_dout", 32'(data_out), 32'h3);

        // random key segments with sparse loads and occasional resets
        for (int s = 0; s < 250; s++) begin
            int len;
            bit lvl;
            len = $urandom_range(1, 28);
            lvl = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++)
                cyc(lvl, $urandom_range(0, 15) == 0, 4'($urandom));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
